lint32_to_axi_bridge: RTL and testbench
=======================================

Name: lint32_to_axi_bridge

Overview:
- Converts a single 32-bit TCDM/LINT initiator (FC data, debug or a HWPE port) into single-beat AXI4 transactions on a 32-bit AXI4 master port.
- It is the reverse of the existing 64-bit AXI-to-LINT bridge. It lets a LINT-side initiator reach AXI-only targets (cluster plug, wide ALU) without going through the SoC interconnect.
- At most one transaction is in flight; responses return in order.

Parameters:
AXI_ID_WIDTH, 6, width of all AXI ID fields
AXI_USER_WIDTH, 6, width of all AXI user fields
AXI_ID, 0, constant ID driven on aw_id_o/ar_id_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  LINT request
add_i  in  32  LINT byte address
wen_i  in  1  LINT write-enable, active-low (1=read, 0=write)
wdata_i  in  32  LINT write data
be_i  in  4  LINT byte enables
gnt_o  out  1  LINT grant
r_valid_o  out  1  LINT response valid, one-cycle pulse
r_rdata_o  out  32  LINT read data
r_opc_o  out  1  LINT response error flag
aw_id_o/aw_addr_o/aw_user_o  out  AXI_ID_WIDTH/32/AXI_USER_WIDTH  write address channel
aw_valid_o / aw_ready_i  out/in  1  AW handshake
w_data_o/w_strb_o/w_last_o  out  32/4/1  write data channel
w_valid_o / w_ready_i  out/in  1  W handshake
b_id_i/b_resp_i  in  AXI_ID_WIDTH/2  write response
b_valid_i / b_ready_o  in/out  1  B handshake
ar_id_o/ar_addr_o/ar_user_o  out  AXI_ID_WIDTH/32/AXI_USER_WIDTH  read address channel
ar_valid_o / ar_ready_i  out/in  1  AR handshake
r_id_i/r_data_i/r_resp_i/r_last_i  in  AXI_ID_WIDTH/32/2/1  read data channel
r_valid_i / r_ready_o  in/out  1  R handshake
Tied-off AXI fields (out, constant): len=0, size=3'b010, burst=INCR, lock/cache/prot/qos/region/atop=0, user=0.

Behaviour:
- Reset: state IDLE. gnt_o, r_valid_o, r_opc_o, and all AXI valid/ready outputs are 0; r_rdata_o is 0; captured request registers are 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - gnt_o = req_i combinationally; gnt_o is 0 in every other state.
  - On req_i&gnt_o in cycle T, register {add_i[31:2],2'b00}, wdata_i, be_i and wen_i.
  - Next state is RD_REQ if wen_i=1, otherwise WR_REQ.
- WR_REQ (entered at T+1):
  - aw_valid_o and w_valid_o are both asserted from T+1. w_last_o=1; w_strb_o = captured be.
  - Each valid drops in the cycle after its own handshake; the two channels complete independently in either order or in the same cycle.
  - Once both handshakes are done, go to WR_RESP.
  - Valid is never withdrawn before its handshake; the payload is stable while valid is high.
- WR_RESP:
  - b_ready_o=1.
  - On b_valid_i at cycle X: r_valid_o=1 and r_rdata_o=0 at X+1, with r_opc_o = (b_resp_i[1]==1).
  - State returns to IDLE at X+1, so a new grant may coincide with the r_valid_o pulse.
- RD_REQ: ar_valid_o=1 from T+1 until the handshake, then RD_RESP.
- RD_RESP:
  - r_ready_o=1.
  - On r_valid_i at X: r_rdata_o=r_data_i, r_valid_o=1 at X+1, r_opc_o = (r_resp_i[1] | ~r_last_i).
  - Return to IDLE.
- Outside the pulse: r_valid_o is 1 for exactly one cycle; r_rdata_o holds its last value; r_opc_o returns to 0.
- Minimum latency (all AXI readies high, response one cycle after the address handshake): grant T, AXI handshake T+1, response T+2, r_valid_o T+3.
- b_id_i and r_id_i are ignored; the single-outstanding rule guarantees ordering.
- Stray b_valid_i or r_valid_i outside the WR_RESP/RD_RESP states is not accepted (ready is 0).
- Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values, and no response is issued for the aborted request.
- Unaligned add_i: the low 2 bits are dropped and be_i is passed through unchanged.

Test Plan:
- Write add=0x1C00_0006, wdata=0xDEADBEEF, be=4'b1100, all readies high, b_resp=OKAY at T+2 -> gnt at T; aw_addr=0x1C00_0004, w_strb=4'b1100 at T+1; r_valid=1, r_opc=0 at T+3.
- Read add=0x1A10_0000, ar_ready delayed 3 cycles, r_data=0x12345678, r_resp=OKAY, r_last=1 -> ar_valid held stable for 4 cycles; r_rdata=0x12345678 pulse one cycle after the R beat.
- Write with w_ready at T+1 but aw_ready at T+4 -> w_valid drops at T+2, aw_valid held until T+4, b_ready rises at T+5; then B with SLVERR -> r_opc=1.
- Back-to-back: second req held high during the first transaction -> gnt=0 until the state is IDLE; second gnt coincides with the first r_valid pulse.
- Read returns DECERR, and separately r_last=0 with OKAY -> r_opc=1 in both cases.
- rst_ni pulsed low while in WR_REQ with aw_valid high -> aw_valid, w_valid and gnt drop to 0 asynchronously; no r_valid afterwards; the next request completes normally.

Source files
------------

// File: rtl/lint32_to_axi_bridge.sv
// Bridges one 32-bit LINT initiator onto a 32-bit AXI4 master port using single-beat bursts.
// Only one transaction is ever outstanding, so AXI IDs are constant and responses stay in order.
module lint32_to_axi_bridge #(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [31:0]               r_rdata_o,
    output logic                      r_opc_o,

    output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
    output logic [31:0]               aw_addr_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic                      aw_lock_o,
    output logic [3:0]                aw_cache_o,
    output logic [2:0]                aw_prot_o,
    output logic [3:0]                aw_qos_o,
    output logic [3:0]                aw_region_o,
    output logic [5:0]                aw_atop_o,
    output logic [AXI_USER_WIDTH-1:0] aw_user_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,

    output logic [31:0]               w_data_o,
    output logic [3:0]                w_strb_o,
    output logic                      w_last_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,

    input  logic [AXI_ID_WIDTH-1:0]   b_id_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,

    output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
    output logic [31:0]               ar_addr_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic                      ar_lock_o,
    output logic [3:0]                ar_cache_o,
    output logic [2:0]                ar_prot_o,
    output logic [3:0]                ar_qos_o,
    output logic [3:0]                ar_region_o,
    output logic [AXI_USER_WIDTH-1:0] ar_user_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,

    input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
    input  logic [31:0]               r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        awValid_q;
    logic        wValid_q;
    logic        arValid_q;
    logic        rValid_q;
    logic [31:0] rdata_q;
    logic        rOpc_q;

    logic        awPending;
    logic        wPending;

    // IDs, low address bits and the low response bits carry no information here.
    logic        unused_inputs;
    assign unused_inputs = ^{add_i[1:0], b_id_i, b_resp_i[0], r_id_i, r_resp_i[0]};

    // A channel is still pending while its valid is up and the handshake has not happened yet.
    assign awPending = awValid_q & ~aw_ready_i;
    assign wPending  = wValid_q  & ~w_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            arValid_q <= 1'b0;
            rValid_q  <= 1'b0;
            rdata_q   <= '0;
            rOpc_q    <= 1'b0;
        end else begin
            rValid_q <= 1'b0;
            rOpc_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= {add_i[31:2], 2'b00};
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (wen_i) begin
                            state_q   <= RD_REQ;
                            arValid_q <= 1'b1;
                        end else begin
                            state_q   <= WR_REQ;
                            awValid_q <= 1'b1;
                            wValid_q  <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_ready_i) awValid_q <= 1'b0;
                    if (w_ready_i)  wValid_q  <= 1'b0;
                    if (!awPending && !wPending) state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        state_q  <= IDLE;
                        rValid_q <= 1'b1;
                        rdata_q  <= '0;
                        rOpc_q   <= b_resp_i[1];
                    end
                end
                RD_REQ: begin
                    if (ar_ready_i) begin
                        arValid_q <= 1'b0;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_valid_i) begin
                        state_q  <= IDLE;
                        rValid_q <= 1'b1;
                        rdata_q  <= r_data_i;
                        rOpc_q   <= r_resp_i[1] | ~r_last_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is combinational so a request can be taken in the same cycle a response pulses.
    assign gnt_o     = req_i & rst_ni & (state_q == IDLE);
    assign r_valid_o = rValid_q;
    assign r_rdata_o = rdata_q;
    assign r_opc_o   = rOpc_q;

    assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign aw_addr_o   = addr_q;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = 3'b010;
    assign aw_burst_o  = 2'b01;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign aw_atop_o   = 6'd0;
    assign aw_user_o   = '0;
    assign aw_valid_o  = awValid_q;

    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign w_last_o  = 1'b1;
    assign w_valid_o = wValid_q;

    assign b_ready_o = (state_q == WR_RESP);

    assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = 3'b010;
    assign ar_burst_o  = 2'b01;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_region_o = 4'd0;
    assign ar_user_o   = '0;
    assign ar_valid_o  = arValid_q;

    assign r_ready_o = (state_q == RD_RESP);

endmodule

// File: tb/tb_lint32_to_axi_bridge.sv
// Self-checking bench for lint32_to_axi_bridge: directed table, hand-written corner sequences,
// then random traffic checked against a transaction-level model of the bridge.
module tb_lint32_to_axi_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_opc_o;

    logic [5:0]  aw_id_o;
    logic [31:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        aw_lock_o;
    logic [3:0]  aw_cache_o;
    logic [2:0]  aw_prot_o;
    logic [3:0]  aw_qos_o;
    logic [3:0]  aw_region_o;
    logic [5:0]  aw_atop_o;
    logic [5:0]  aw_user_o;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_last_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [5:0]  b_id_i;
    logic [1:0]  b_resp_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [5:0]  ar_id_o;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        ar_lock_o;
    logic [3:0]  ar_cache_o;
    logic [2:0]  ar_prot_o;
    logic [3:0]  ar_qos_o;
    logic [3:0]  ar_region_o;
    logic [5:0]  ar_user_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [5:0]  r_id_i;
    logic [31:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_last_i;
    logic        r_valid_i;
    logic        r_ready_o;

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clk_i = ~clk_i;

    lint32_to_axi_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
        .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o),
        .aw_prot_o(aw_prot_o), .aw_qos_o(aw_qos_o), .aw_region_o(aw_region_o),
        .aw_atop_o(aw_atop_o), .aw_user_o(aw_user_o), .aw_valid_o(aw_valid_o),
        .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o),
        .ar_prot_o(ar_prot_o), .ar_qos_o(ar_qos_o), .ar_region_o(ar_region_o),
        .ar_user_o(ar_user_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  resp;
        logic        rlast;
        logic [31:0] rdata;
        logic [31:0] expAddr;
        logic        expOpc;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idleInputs();
        req_i = 1'b0; add_i = '0; wen_i = 1'b1; wdata_i = '0; be_i = '0;
        aw_ready_i = 1'b1; w_ready_i = 1'b1; ar_ready_i = 1'b1;
        b_id_i = '0; b_resp_i = '0; b_valid_i = 1'b0;
        r_id_i = '0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b1; r_valid_i = 1'b0;
    endtask

    // One minimum-latency transaction: grant T, address/data T+1, response T+2, pulse T+3.
    task automatic applyStimulus(input vec_t v);
        req_i = 1'b1; add_i = v.add; wen_i = v.wen; wdata_i = v.wdata; be_i = v.be;
        aw_ready_i = 1'b1; w_ready_i = 1'b1; ar_ready_i = 1'b1;
        sample();
        checkBit("gnt@T", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0; wen_i = 1'b1;
        sample();
        if (!v.wen) begin
            checkBit("awValid@T+1", aw_valid_o, 1'b1);
            checkOutput("awAddr@T+1", aw_addr_o, v.expAddr);
            checkBit("wValid@T+1", w_valid_o, 1'b1);
            checkOutput("wData@T+1", w_data_o, v.wdata);
            checkOutput("wStrb@T+1", {28'd0, w_strb_o}, {28'd0, v.be});
        end else begin
            checkBit("arValid@T+1", ar_valid_o, 1'b1);
            checkOutput("arAddr@T+1", ar_addr_o, v.expAddr);
        end
        cyc();
        if (!v.wen) begin
            b_valid_i = 1'b1; b_resp_i = v.resp;
        end else begin
            r_valid_i = 1'b1; r_data_i = v.rdata; r_resp_i = v.resp; r_last_i = v.rlast;
        end
        sample();
        checkBit("respReady@T+2", v.wen ? r_ready_o : b_ready_o, 1'b1);
        checkBit("addrValidLow@T+2", aw_valid_o | w_valid_o | ar_valid_o, 1'b0);
        checkBit("rValid@T+2", r_valid_o, 1'b0);
        cyc();
        b_valid_i = 1'b0; r_valid_i = 1'b0; r_last_i = 1'b1;
        sample();
        checkBit("rValid@T+3", r_valid_o, 1'b1);
        checkOutput("rRdata@T+3", r_rdata_o, v.expRdata);
        checkBit("rOpc@T+3", r_opc_o, v.expOpc);
        cyc();
        sample();
        checkBit("rValid@T+4", r_valid_o, 1'b0);
        checkBit("rOpc@T+4", r_opc_o, 1'b0);
        checkOutput("rRdataHold@T+4", r_rdata_o, v.expRdata);
        cyc();
    endtask

    // Transaction-level reference state for the random phase.
    bit          mBusy, mIsWrite, mAwDone, mWDone, mArDone, mRespPending, mOpc;
    bit          eGnt, eAw, eW, eB, eAr, eR;
    logic [31:0] mAddr, mData, mRdata;
    logic [3:0]  mStrb;

    initial begin
        vecs[0] = '{1'b0, 32'h1C00_0006, 32'hDEAD_BEEF, 4'b1100, 2'b00, 1'b1, 32'h0, 32'h1C00_0004, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0003, 32'hCAFE_F00D, 4'b0001, 2'b10, 1'b1, 32'h0, 32'h0000_0000, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0123_4567, 4'b1111, 2'b01, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h1A10_0000, 32'h0, 4'b1111, 2'b00, 1'b1, 32'h1234_5678, 32'h1A10_0000, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h1A10_0001, 32'h0, 4'b1111, 2'b11, 1'b1, 32'hA5A5_A5A5, 32'h1A10_0000, 1'b1, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 32'h2000_0008, 32'h0, 4'b0000, 2'b00, 1'b0, 32'h0F0F_0F0F, 32'h2000_0008, 1'b1, 32'h0F0F_0F0F};
        vecs[6] = '{1'b0, 32'h8000_0012, 32'h7777_8888, 4'b0110, 2'b00, 1'b1, 32'h0, 32'h8000_0010, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0FFE, 32'h0, 4'b1010, 2'b01, 1'b1, 32'h600D_F00D, 32'h0000_0FFC, 1'b0, 32'h600D_F00D};

        // Reset values, with a request already pending that must not be granted.
        idleInputs();
        req_i = 1'b1;
        rst_ni = 1'b0;
        #3;
        checkBit("rst gnt", gnt_o, 1'b0);
        checkBit("rst awValid", aw_valid_o, 1'b0);
        checkBit("rst wValid", w_valid_o, 1'b0);
        checkBit("rst arValid", ar_valid_o, 1'b0);
        checkBit("rst bReady", b_ready_o, 1'b0);
        checkBit("rst rReady", r_ready_o, 1'b0);
        checkBit("rst rValid", r_valid_o, 1'b0);
        checkBit("rst rOpc", r_opc_o, 1'b0);
        checkOutput("rst rRdata", r_rdata_o, 32'h0);
        checkOutput("awSize", {29'd0, aw_size_o}, 32'd2);
        checkOutput("arBurst", {30'd0, ar_burst_o}, 32'd1);
        checkOutput("awLen", {24'd0, aw_len_o}, 32'd0);
        checkOutput("awId", {26'd0, aw_id_o}, 32'd0);
        checkBit("wLast", w_last_o, 1'b1);
        cyc();
        cyc();
        rst_ni = 1'b1;
        req_i = 1'b0;
        cyc();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Read with ar_ready held off for three cycles.
        req_i = 1'b1; add_i = 32'h1A10_0000; wen_i = 1'b1; ar_ready_i = 1'b0;
        sample();
        checkBit("A gnt", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checkBit("A arValid held", ar_valid_o, 1'b1);
            checkOutput("A arAddr stable", ar_addr_o, 32'h1A10_0000);
            checkBit("A rReady early", r_ready_o, 1'b0);
            cyc();
        end
        ar_ready_i = 1'b1;
        sample();
        checkBit("A arValid 4th", ar_valid_o, 1'b1);
        cyc();
        r_valid_i = 1'b1; r_data_i = 32'h1234_5678; r_resp_i = 2'b00; r_last_i = 1'b1;
        sample();
        checkBit("A arValid drop", ar_valid_o, 1'b0);
        checkBit("A rReady", r_ready_o, 1'b1);
        checkBit("A rValid early", r_valid_o, 1'b0);
        cyc();
        r_valid_i = 1'b0;
        sample();
        checkBit("A rValid", r_valid_o, 1'b1);
        checkOutput("A rRdata", r_rdata_o, 32'h1234_5678);
        checkBit("A rOpc", r_opc_o, 1'b0);
        cyc();
        sample();
        checkBit("A rValid pulse", r_valid_o, 1'b0);
        cyc();

        // Write where W completes at T+1 but AW only at T+4, then SLVERR.
        req_i = 1'b1; add_i = 32'h1C00_1000; wen_i = 1'b0; wdata_i = 32'h55AA_55AA; be_i = 4'b0011;
        aw_ready_i = 1'b0; w_ready_i = 1'b1;
        sample();
        checkBit("B gnt", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0; wen_i = 1'b1;
        sample();
        checkBit("B awValid T+1", aw_valid_o, 1'b1);
        checkBit("B wValid T+1", w_valid_o, 1'b1);
        cyc();
        w_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            checkBit("B wValid dropped", w_valid_o, 1'b0);
            checkBit("B awValid held", aw_valid_o, 1'b1);
            checkBit("B bReady early", b_ready_o, 1'b0);
            cyc();
        end
        aw_ready_i = 1'b1;
        sample();
        checkBit("B awValid T+4", aw_valid_o, 1'b1);
        checkBit("B bReady T+4", b_ready_o, 1'b0);
        cyc();
        b_valid_i = 1'b1; b_resp_i = 2'b10;
        sample();
        checkBit("B awValid T+5", aw_valid_o, 1'b0);
        checkBit("B bReady T+5", b_ready_o, 1'b1);
        cyc();
        b_valid_i = 1'b0; b_resp_i = 2'b00;
        sample();
        checkBit("B rValid", r_valid_o, 1'b1);
        checkBit("B rOpc", r_opc_o, 1'b1);
        checkOutput("B rRdata", r_rdata_o, 32'h0);
        cyc();
        sample();
        checkBit("B rOpc clear", r_opc_o, 1'b0);
        cyc();

        // Back-to-back: second request held; its grant lands on the first response pulse.
        w_ready_i = 1'b1; aw_ready_i = 1'b1; ar_ready_i = 1'b1;
        req_i = 1'b1; add_i = 32'h5000_0004; wen_i = 1'b0; wdata_i = 32'h1111_2222; be_i = 4'b1111;
        sample();
        checkBit("C gnt1", gnt_o, 1'b1);
        cyc();
        add_i = 32'h3000_0000; wen_i = 1'b1;
        sample();
        checkBit("C gnt blocked T+1", gnt_o, 1'b0);
        checkOutput("C awAddr", aw_addr_o, 32'h5000_0004);
        cyc();
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        sample();
        checkBit("C gnt blocked T+2", gnt_o, 1'b0);
        cyc();
        b_valid_i = 1'b0;
        sample();
        checkBit("C rValid first", r_valid_o, 1'b1);
        checkBit("C gnt2 with pulse", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'h9ABC_DEF0; r_resp_i = 2'b00; r_last_i = 1'b1;
        sample();
        checkBit("C stray R ignored", r_valid_o, 1'b0);
        checkBit("C rReady in RD_REQ", r_ready_o, 1'b0);
        checkOutput("C arAddr", ar_addr_o, 32'h3000_0000);
        cyc();
        sample();
        checkBit("C rReady", r_ready_o, 1'b1);
        checkBit("C rValid early", r_valid_o, 1'b0);
        cyc();
        r_valid_i = 1'b0;
        sample();
        checkBit("C rValid second", r_valid_o, 1'b1);
        checkOutput("C rRdata", r_rdata_o, 32'h9ABC_DEF0);
        cyc();

        // Reset while AW/W are still waiting; the aborted write must produce no response.
        req_i = 1'b1; add_i = 32'h4000_0000; wen_i = 1'b0; wdata_i = 32'hFEED_FACE; be_i = 4'b1111;
        aw_ready_i = 1'b0; w_ready_i = 1'b0;
        sample();
        checkBit("D gnt", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0; wen_i = 1'b1;
        sample();
        checkBit("D awValid before rst", aw_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0; req_i = 1'b1; b_valid_i = 1'b1;
        #1;
        checkBit("D awValid async", aw_valid_o, 1'b0);
        checkBit("D wValid async", w_valid_o, 1'b0);
        checkBit("D gnt in rst", gnt_o, 1'b0);
        cyc();
        cyc();
        rst_ni = 1'b1; req_i = 1'b0; aw_ready_i = 1'b1; w_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            checkBit("D no rValid", r_valid_o, 1'b0);
            checkBit("D bReady", b_ready_o, 1'b0);
            checkBit("D awValid", aw_valid_o, 1'b0);
            cyc();
        end
        b_valid_i = 1'b0;
        applyStimulus(vecs[0]);

        // Random traffic against the transaction-level model, starting from a fresh reset.
        idleInputs();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        mBusy = 1'b0; mRespPending = 1'b0; mOpc = 1'b0; mRdata = '0;
        mIsWrite = 1'b0; mAwDone = 1'b0; mWDone = 1'b0; mArDone = 1'b0;
        mAddr = '0; mData = '0; mStrb = '0;
        for (int c = 0; c < 3000; c++) begin
            req_i      = ($urandom_range(0, 2) != 0);
            add_i      = $urandom;
            wen_i      = ($urandom_range(0, 1) != 0);
            wdata_i    = $urandom;
            be_i       = 4'($urandom_range(0, 15));
            aw_ready_i = ($urandom_range(0, 2) != 0);
            w_ready_i  = ($urandom_range(0, 2) != 0);
            ar_ready_i = ($urandom_range(0, 2) != 0);
            b_valid_i  = ($urandom_range(0, 2) == 0);
            b_resp_i   = 2'($urandom_range(0, 3));
            b_id_i     = 6'($urandom_range(0, 63));
            r_valid_i  = ($urandom_range(0, 2) == 0);
            r_data_i   = $urandom;
            r_resp_i   = 2'($urandom_range(0, 3));
            r_last_i   = ($urandom_range(0, 3) != 0);
            r_id_i     = 6'($urandom_range(0, 63));
            sample();

            eGnt = req_i && !mBusy;
            eAw  = mBusy && mIsWrite && !mAwDone;
            eW   = mBusy && mIsWrite && !mWDone;
            eB   = mBusy && mIsWrite && mAwDone && mWDone;
            eAr  = mBusy && !mIsWrite && !mArDone;
            eR   = mBusy && !mIsWrite && mArDone;
            checkBit("R gnt", gnt_o, eGnt);
            checkBit("R awValid", aw_valid_o, eAw);
            checkBit("R wValid", w_valid_o, eW);
            checkBit("R bReady", b_ready_o, eB);
            checkBit("R arValid", ar_valid_o, eAr);
            checkBit("R rReady", r_ready_o, eR);
            if (eAw) checkOutput("R awAddr", aw_addr_o, mAddr);
            if (eAr) checkOutput("R arAddr", ar_addr_o, mAddr);
            if (eW) begin
                checkOutput("R wData", w_data_o, mData);
                checkOutput("R wStrb", {28'd0, w_strb_o}, {28'd0, mStrb});
            end
            checkBit("R rValid", r_valid_o, mRespPending);
            checkBit("R rOpc", r_opc_o, mRespPending && mOpc);
            checkOutput("R rRdata", r_rdata_o, mRdata);

            mRespPending = 1'b0;
            if (mBusy) begin
                if (eAw && aw_ready_i) mAwDone = 1'b1;
                if (eW && w_ready_i) mWDone = 1'b1;
                if (eAr && ar_ready_i) mArDone = 1'b1;
                if (eB && b_valid_i) begin
                    mBusy = 1'b0; mRespPending = 1'b1; mRdata = '0; mOpc = b_resp_i[1];
                end
                if (eR && r_valid_i) begin
                    mBusy = 1'b0; mRespPending = 1'b1; mRdata = r_data_i;
                    mOpc = r_resp_i[1] || !r_last_i;
                end
            end else if (req_i) begin
                mBusy = 1'b1; mIsWrite = !wen_i;
                mAwDone = 1'b0; mWDone = 1'b0; mArDone = 1'b0;
                mAddr = add_i & 32'hFFFF_FFFC; mData = wdata_i; mStrb = be_i;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
